// File: rtl/tx_sample_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_sample_arbiter_if
// Brief    : Sample-source and DAC handshake bundle for the TX sample arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_sample_arbiter_if #(
    parameter int DW = 12
);
    logic          req0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic [1:0]    grant;
    logic [1:0]    daccmd;
    logic [DW-1:0] dac_data;
    logic          dacdav;
    logic          davdac;

    // The arbiter is the master: it consumes source samples and drives the DAC.
    modport master (
        input  req0, data0, req1, data1, davdac,
        output ack0, ack1, grant, daccmd, dac_data, dacdav
    );

    modport slave (
        output req0, data0, req1, data1, davdac,
        input  ack0, ack1, grant, daccmd, dac_data, dacdav
    );
endinterface
`default_nettype wire

// File: rtl/tx_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_sample_arbiter
// Brief    : Round-robin burst arbiter sharing the TX DAC between the DDS
//            source (0) and the baseband source (1) via dacdav/davdac.
// Revision : 1.0 - initial release
// ============================================================================
module tx_sample_arbiter #(
    parameter int DW      = 12,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic              clr_err,
    output logic                   timeout_err,
    tx_sample_arbiter_if.master    bus
);

    localparam int c_CNT_W = $clog2(BURST + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARB  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;
    localparam logic [1:0] c_WAIT = 2'd3;

    localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(BURST);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST   = c_TMR_W'(TIMEOUT);

    logic [1:0]         r_state;
    logic               r_last;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [1:0]         r_grant;
    logic               r_ack0;
    logic               r_ack1;
    logic [DW-1:0]      r_dac_data;
    logic               r_dacdav;
    logic               r_timeout_err;

    logic               w_any_req;
    logic               w_pick1;
    logic               w_sel_req;
    logic [DW-1:0]      w_sel_data;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_TMR_W-1:0] w_tmr_nxt;

    // On a tie the source that did not own the previous grant wins.
    assign w_any_req  = bus.req0 | bus.req1;
    assign w_pick1    = bus.req1 & (~bus.req0 | ~r_last);
    assign w_sel_req  = r_grant[1] ? bus.req1  : bus.req0;
    assign w_sel_data = r_grant[1] ? bus.data1 : bus.data0;
    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign w_tmr_nxt  = r_timer + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_last        <= 1'b1;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_grant       <= 2'b00;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_dac_data    <= '0;
            r_dacdav      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            // A timeout in the WAIT branch below overrides this clear.
            if (clr_err) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (en) begin
                        r_state <= c_ARB;
                    end
                end

                c_ARB: begin
                    if (!en) begin
                        r_state <= c_IDLE;
                    end else if (w_any_req) begin
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_last  <= w_pick1;
                        r_cnt   <= '0;
                        r_state <= c_LOAD;
                    end
                end

                c_LOAD: begin
                    if (w_sel_req) begin
                        r_dac_data <= w_sel_data;
                        r_ack0     <= r_grant[0];
                        r_ack1     <= r_grant[1];
                        r_dacdav   <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= c_WAIT;
                    end else begin
                        r_grant <= 2'b00;
                        r_state <= c_ARB;
                    end
                end

                c_WAIT: begin
                    if (bus.davdac) begin
                        r_dacdav <= 1'b0;
                        r_cnt    <= w_cnt_nxt;
                        if (!en) begin
                            r_grant <= 2'b00;
                            r_state <= c_IDLE;
                        end else if (w_cnt_nxt == c_BURST_LAST) begin
                            r_grant <= 2'b00;
                            r_state <= c_ARB;
                        end else begin
                            r_state <= c_LOAD;
                        end
                    end else if (w_tmr_nxt == c_TMR_LAST) begin
                        // Sample is dropped; its ack already fired at load.
                        r_dacdav      <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_grant       <= 2'b00;
                        r_state       <= c_ARB;
                    end else begin
                        r_timer <= w_tmr_nxt;
                    end
                end

                default: begin
                    r_grant  <= 2'b00;
                    r_dacdav <= 1'b0;
                    r_state  <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.grant    = r_grant;
    assign bus.daccmd   = r_grant;
    assign bus.dac_data = r_dac_data;
    assign bus.dacdav   = r_dacdav;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
